// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register indices and
// enables in, forwarding selects, stall/flush controls and counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_WIDTH = 5,
  parameter int unsigned CNT_WIDTH = 32
);
  logic [REG_WIDTH-1:0] rs1_d;
  logic [REG_WIDTH-1:0] rs2_d;
  logic [REG_WIDTH-1:0] rs1_e;
  logic [REG_WIDTH-1:0] rs2_e;
  logic [REG_WIDTH-1:0] rd_e;
  logic                 reg_write_e;
  logic [1:0]           result_src_e;
  logic                 mc_op_e;
  logic                 pc_src_e;
  logic [REG_WIDTH-1:0] rd_m;
  logic                 reg_write_m;
  logic [REG_WIDTH-1:0] rd_w;
  logic                 reg_write_w;
  logic                 clr_cnt;

  logic [1:0]           forward_a;
  logic [1:0]           forward_b;
  logic                 stall_f;
  logic                 stall_d;
  logic                 stall_e;
  logic                 flush_d;
  logic                 flush_e;
  logic                 flush_m;
  logic                 mc_busy;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, reg_write_e, result_src_e,
           mc_op_e, pc_src_e, rd_m, reg_write_m, rd_w, reg_write_w, clr_cnt,
    input  forward_a, forward_b, stall_f, stall_d, stall_e,
           flush_d, flush_e, flush_m, mc_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, reg_write_e, result_src_e,
           mc_op_e, pc_src_e, rd_m, reg_write_m, rd_w, reg_write_w, clr_cnt,
    output forward_a, forward_b, stall_f, stall_d, stall_e,
           flush_d, flush_e, flush_m, mc_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stall,
// branch flush, multi-cycle E-stage occupancy FSM and stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_WIDTH = 5,
  parameter int unsigned MC_LAT    = 4,
  parameter logic [1:0]  LOAD_SRC  = 2'b01,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  io_hz
);

  localparam logic [REG_WIDTH-1:0] ZERO_REG = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam bit                   MC_EN    = (MC_LAT > 1);
  localparam logic [3:0]           REM_INIT = 4'(MC_LAT - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [3:0]           r_rem;
  logic                 r_mc_busy;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic       w_lw_stall;
  logic       w_mc_stall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_flush_d;
  logic       w_flush_e;
  logic       w_flush_m;

  // M has priority over W since it holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_WIDTH-1:0] rs,
    input logic [REG_WIDTH-1:0] rd_m,
    input logic                 wr_m,
    input logic [REG_WIDTH-1:0] rd_w,
    input logic                 wr_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != ZERO_REG) begin
      if (wr_m && (rs == rd_m))      sel = 2'b10;
      else if (wr_w && (rs == rd_w)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    w_fwd_a = fwd_sel(io_hz.rs1_e, io_hz.rd_m, io_hz.reg_write_m,
                      io_hz.rd_w, io_hz.reg_write_w);
    w_fwd_b = fwd_sel(io_hz.rs2_e, io_hz.rd_m, io_hz.reg_write_m,
                      io_hz.rd_w, io_hz.reg_write_w);
  end

  // The multi-cycle op is never killed: its stall overrides load-use and branch.
  always_comb begin
    w_lw_stall = (io_hz.result_src_e == LOAD_SRC) && io_hz.reg_write_e &&
                 (io_hz.rd_e != ZERO_REG) &&
                 ((io_hz.rs1_d == io_hz.rd_e) || (io_hz.rs2_d == io_hz.rd_e));
    w_mc_stall = ((r_state == ST_IDLE) && io_hz.mc_op_e && MC_EN) ||
                 (r_state == ST_BUSY);
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_m = 1'b0;
    if (w_mc_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_flush_m = 1'b1;
    end else begin
      w_stall_f = w_lw_stall || io_hz.pc_src_e;
      w_stall_d = w_lw_stall || io_hz.pc_src_e;
      w_flush_e = w_lw_stall || io_hz.pc_src_e;
      w_flush_d = io_hz.pc_src_e;
    end
  end

  // Occupancy FSM: the IDLE cycle plus MC_LAT-2 BUSY cycles stall, DONE releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rem     <= 4'd0;
      r_mc_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_hz.mc_op_e && MC_EN) begin
            r_rem     <= REM_INIT;
            r_state   <= (MC_LAT == 2) ? ST_DONE : ST_BUSY;
            r_mc_busy <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (r_rem == 4'd1) begin
            r_rem   <= 4'd0;
            r_state <= ST_DONE;
          end else begin
            r_rem <= r_rem - 4'd1;
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_mc_busy <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_rem     <= 4'd0;
          r_mc_busy <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (io_hz.clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_f && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (w_flush_d && (r_flush_cnt != CNT_MAX)) r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign io_hz.forward_a = w_fwd_a;
  assign io_hz.forward_b = w_fwd_b;
  assign io_hz.stall_f   = w_stall_f;
  assign io_hz.stall_d   = w_stall_d;
  assign io_hz.stall_e   = w_stall_e;
  assign io_hz.flush_d   = w_flush_d;
  assign io_hz.flush_e   = w_flush_e;
  assign io_hz.flush_m   = w_flush_m;
  assign io_hz.mc_busy   = r_mc_busy;
  assign io_hz.stall_cnt = r_stall_cnt;
  assign io_hz.flush_cnt = r_flush_cnt;

endmodule
